// File: rtl/mux3_arbiter_pkg.sv
// Shared definitions for the three-requester burst arbiter: FSM states,
// selector codes and the owner-to-grant/selector mappings.
package mux3_arbiter_pkg;

    typedef enum logic {
        StIdle  = 1'b0,
        StGrant = 1'b1
    } state_e;

    localparam logic [1:0] SEL0 = 2'b00;
    localparam logic [1:0] SEL1 = 2'b01;
    localparam logic [1:0] SEL2 = 2'b10;

    localparam logic [1:0] LAST_OWNER_RST = 2'd2;

    function automatic logic [1:0] owner_to_sel(input logic [1:0] owner);
        logic [1:0] sel;
        case (owner)
            2'd0:    sel = SEL0;
            2'd1:    sel = SEL1;
            2'd2:    sel = SEL2;
            default: sel = SEL0;
        endcase
        return sel;
    endfunction

    function automatic logic [2:0] owner_to_gnt(input logic [1:0] owner);
        logic [2:0] gnt;
        case (owner)
            2'd0:    gnt = 3'b001;
            2'd1:    gnt = 3'b010;
            2'd2:    gnt = 3'b100;
            default: gnt = 3'b000;
        endcase
        return gnt;
    endfunction

    // Round-robin pick: first set request starting just after the last owner.
    function automatic logic [1:0] pick_owner(input logic [1:0] last, input logic [2:0] req);
        logic [1:0] first;
        logic [1:0] second;
        logic [1:0] third;
        logic [1:0] pick;
        case (last)
            2'd0: begin first = 2'd1; second = 2'd2; third = 2'd0; end
            2'd1: begin first = 2'd2; second = 2'd0; third = 2'd1; end
            default: begin first = 2'd0; second = 2'd1; third = 2'd2; end
        endcase
        if (req[first]) begin
            pick = first;
        end else if (req[second]) begin
            pick = second;
        end else begin
            pick = third;
        end
        return pick;
    endfunction

endpackage

// File: rtl/mux3_arbiter_if.sv
// Requester/output bundle of the arbiter; slave is the arbiter side,
// master is the side driving requests and payloads.
interface mux3_arbiter_if #(
    parameter int unsigned size = 32
) ();
    logic [2:0]      req_i;
    logic [size-1:0] data0_i;
    logic [size-1:0] data1_i;
    logic [size-1:0] data2_i;
    logic [2:0]      gnt_o;
    logic [1:0]      select_o;
    logic [size-1:0] data_o;
    logic            valid_o;
    logic            busy_o;

    modport slave (
        input  req_i, data0_i, data1_i, data2_i,
        output gnt_o, select_o, data_o, valid_o, busy_o
    );

    modport master (
        output req_i, data0_i, data1_i, data2_i,
        input  gnt_o, select_o, data_o, valid_o, busy_o
    );
endinterface

// File: rtl/MUX_3to1.sv
// Plain 3:1 payload selector; codes outside 00/01/10 fall back to input 0.
module MUX_3to1 #(
    parameter int unsigned size = 32
) (
    input  logic [size-1:0] in0,
    input  logic [size-1:0] in1,
    input  logic [size-1:0] in2,
    input  logic [1:0]      select,
    output logic [size-1:0] out
);
    always_comb begin
        out = in0;
        case (select)
            2'b01:   out = in1;
            2'b10:   out = in2;
            default: out = in0;
        endcase
    end
endmodule

// File: rtl/mux3_arbiter.sv
// Round-robin burst arbiter for three requesters: grants up to MAX_BURST
// beats per owner and registers the selected payload onto data_o.
module mux3_arbiter
    import mux3_arbiter_pkg::*;
#(
    parameter int unsigned size      = 32,
    parameter int unsigned MAX_BURST = 4   // legal range 1..15
) (
    input  logic          clk_i,
    input  logic          rst_i,
    mux3_arbiter_if.slave bus
);

    localparam logic [3:0] MaxBurst = 4'(MAX_BURST);

    state_e          state_q;
    logic [1:0]      owner_q;
    logic [1:0]      last_q;
    logic [3:0]      cnt_q;
    logic [size-1:0] mux_out;
    logic            owner_req;
    logic            release_now;

    // select_o is registered and equals the owner code while granted,
    // so the mux output is the owner's payload throughout the burst.
    MUX_3to1 #(
        .size(size)
    ) u_mux (
        .in0   (bus.data0_i),
        .in1   (bus.data1_i),
        .in2   (bus.data2_i),
        .select(bus.select_o),
        .out   (mux_out)
    );

    assign owner_req   = |(bus.req_i & owner_to_gnt(owner_q));
    assign release_now = !owner_req || ((cnt_q + 4'd1) == MaxBurst);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            owner_q      <= 2'd0;
            last_q       <= LAST_OWNER_RST;
            cnt_q        <= 4'd0;
            bus.data_o   <= '0;
            bus.valid_o  <= 1'b0;
            bus.gnt_o    <= 3'b000;
            bus.select_o <= SEL0;
            bus.busy_o   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    bus.valid_o <= 1'b0;
                    if (bus.req_i != 3'b000) begin
                        state_q      <= StGrant;
                        owner_q      <= pick_owner(last_q, bus.req_i);
                        cnt_q        <= 4'd0;
                        bus.gnt_o    <= owner_to_gnt(pick_owner(last_q, bus.req_i));
                        bus.select_o <= owner_to_sel(pick_owner(last_q, bus.req_i));
                        bus.busy_o   <= 1'b1;
                    end
                end
                StGrant: begin
                    bus.valid_o <= owner_req;
                    if (owner_req) begin
                        bus.data_o <= mux_out;
                        cnt_q      <= cnt_q + 4'd1;
                    end
                    // Either a dropped request or the final beat ends the burst.
                    if (release_now) begin
                        state_q      <= StIdle;
                        last_q       <= owner_q;
                        bus.gnt_o    <= 3'b000;
                        bus.select_o <= SEL0;
                        bus.busy_o   <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
